rr_arbiter_fsm: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource, such as a datapath or a shared FSM-driven unit, between independent clients. It is built as a multi-segment FSM with three states: IDLE, GRANT and RECOVER. It has registered (Moore) one-hot grant outputs plus a combinational (Mealy) early-grant indication. A hold counter forces release if an owner keeps the resource longer than MAX_HOLD cycles.

---
 rtl/rr_arbiter_fsm.sv | 126 ++++++++++++
 tb/tb_rr_arbiter_fsm.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_fsm.sv
// Four-requester round-robin arbiter: IDLE -> GRANT -> RECOVER -> IDLE, with a
// hold counter that forces release of an owner after MAX_HOLD grant cycles.
module rr_arbiter_fsm #(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [3:0] gnt_early,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t        state, state_next;
  logic [1:0]    owner, owner_next;
  logic [1:0]    ptr, ptr_next;
  logic [CW-1:0] hold_cnt, hold_next;
  logic          to_flag, to_next;

  logic [3:0]    rot;
  logic [1:0]    offset;
  logic [1:0]    winner;
  logic          any_req;

  // Rotate req so bit 0 is the client at ptr, then take the lowest set bit.
  always_comb begin
    any_req = |req;
    rot     = 4'({req, req} >> ptr);
    offset  = 2'd0;
    if (rot[0])      offset = 2'd0;
    else if (rot[1]) offset = 2'd1;
    else if (rot[2]) offset = 2'd2;
    else if (rot[3]) offset = 2'd3;
    winner = ptr + offset;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= 2'd0;
      ptr      <= 2'd0;
      hold_cnt <= '0;
      to_flag  <= 1'b0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      ptr      <= ptr_next;
      hold_cnt <= hold_next;
      to_flag  <= to_next;
    end
  end

  // A voluntary release takes priority over the hold limit on the same cycle.
  always_comb begin
    state_next = state;
    owner_next = owner;
    ptr_next   = ptr;
    hold_next  = hold_cnt;
    to_next    = to_flag;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = GRANT;
          owner_next = winner;
          hold_next  = '0;
        end
      end
      GRANT: begin
        if (done || !req[owner]) begin
          state_next = RECOVER;
          to_next    = 1'b0;
          ptr_next   = owner + 2'd1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = RECOVER;
          to_next    = 1'b1;
          ptr_next   = owner + 2'd1;
        end else begin
          hold_next = hold_cnt + CW'(1);
        end
      end
      RECOVER: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        to_next    = 1'b0;
      end
    endcase
  end

  // gnt_early is the only Mealy output; it is held low while reset is asserted.
  always_comb begin
    gnt       = 4'b0000;
    gnt_early = 4'b0000;
    busy      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (reset && any_req) gnt_early = 4'b0001 << winner;
      end
      GRANT: begin
        gnt  = 4'b0001 << owner;
        busy = 1'b1;
      end
      RECOVER: begin
        busy    = 1'b1;
        timeout = to_flag;
      end
      default: begin
        gnt = 4'b0000;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed bench for rr_arbiter_fsm: stimulus rows push expected outputs into a
// scoreboard queue, and a negedge monitor pops and compares them.
module tb_rr_arbiter_fsm;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [3:0] gnt_early;
  logic       busy;
  logic       timeout;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [3:0] early;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   vectors;
  int   miscompares;

  rr_arbiter_fsm #(.MAX_HOLD(16), .CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_early (gnt_early),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input vector per cycle, just after the rising edge, and queue
  // the outputs expected while that vector is applied.
  task automatic applyStimulus(input string tag, input logic r, input logic [3:0] rq,
                               input logic d, input logic [3:0] eg, input logic [3:0] ee,
                               input logic eb, input logic et, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = r;
      req   = rq;
      done  = d;
      e.tag     = tag;
      e.gnt     = eg;
      e.early   = ee;
      e.busy    = eb;
      e.timeout = et;
      exp_q.push_back(e);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (gnt !== e.gnt || gnt_early !== e.early || busy !== e.busy || timeout !== e.timeout) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got gnt=%b early=%b busy=%b timeout=%b, expected gnt=%b early=%b busy=%b timeout=%b",
               e.tag, $time, gnt, gnt_early, busy, timeout, e.gnt, e.early, e.busy, e.timeout);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checkOutput(cur);
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    req         = 4'b0000;
    done        = 1'b0;

    // Reset held with all requests up, then release
    applyStimulus("rst_hold",     1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3);
    applyStimulus("rst_rel_early",1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1);

    // Round robin with all requests held, done pulsed once per grant
    applyStimulus("rr_g0",   1'b1, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("rr_rec0", 1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("rr_idle1",1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0, 1);
    applyStimulus("rr_g1",   1'b1, 4'b1111, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("rr_rec1", 1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("rr_idle2",1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 1);
    applyStimulus("rr_g2",   1'b1, 4'b1111, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("rr_rec2", 1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("rr_idle3",1'b1, 4'b1111, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, 1);
    applyStimulus("rr_g3",   1'b1, 4'b1111, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("rr_rec3", 1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("rr_idle0",1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1);
    applyStimulus("rr_g0b",  1'b1, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("rr_rec0b",1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("idle_a",  1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);

    // Single request; a foreign request during GRANT must not disturb gnt
    applyStimulus("single_idle", 1'b1, 4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 1);
    applyStimulus("single_g",    1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("single_other",1'b1, 4'b1100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("single_done", 1'b1, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("single_rec",  1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("single_idle2",1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);

    // Forced release after 16 cycles, then pointer moves past the old owner
    applyStimulus("to_idle",     1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0, 1);
    applyStimulus("to_grant",    1'b1, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 16);
    applyStimulus("to_rec",      1'b1, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1);
    applyStimulus("to_next_idle",1'b1, 4'b0011, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1);
    applyStimulus("drop_g1",     1'b1, 4'b0010, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("drop_rec",    1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("idle_b",      1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);

    // done on the last allowed GRANT cycle is a normal release
    applyStimulus("b16_idle",1'b1, 4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 1);
    applyStimulus("b16_g",   1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 15);
    applyStimulus("b16_done",1'b1, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("b16_rec", 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("idle_c",  1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);

    // Reset while client 2 owns the resource clears the pointer
    applyStimulus("mr_idle", 1'b1, 4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 1);
    applyStimulus("mr_g",    1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("mr_rst",  1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("mr_after",1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1);
    applyStimulus("mr_g0",   1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("mr_rec",  1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1);
    applyStimulus("mr_idle2",1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
